// File: rtl/spi_burst_controller.sv
// spi_burst_controller
// Sequencing FSM for the SPI memory datapath. It decodes the command byte,
// owns the data-memory address counter, and issues the one-clk data-memory
// write strobe and shift-register parallel load. After the command byte,
// every further byte is a burst beat at the next address (modulo 2^ADDR_W).
// Bytes beyond MAX_BYTES are neither written nor driven onto MISO.

module spi_burst_controller #(
  parameter int ADDR_W    = 7,
  parameter int MAX_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sclk_posedge,
  input  logic [7:0]        sr_pdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              dm_we,
  output logic              sr_load,
  output logic              miso_en,
  output logic              busy,
  output logic [4:0]        byte_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DECODE,
    WR_DATA,
    WR_COMMIT,
    RD_FETCH,
    RD_LOAD,
    RD_SHIFT
  } state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

  state_t     state;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       below_max;

  // The 8th SCLK rising edge of a byte is the one that wraps the bit counter.
  assign byte_done = sclk_posedge && (bit_cnt == 3'd7);
  assign below_max = (byte_cnt < MAX_CNT);

  // Start address from command bits [7:1], zero-extended or truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
    logic [ADDR_W+6:0] ext;
    ext = {{ADDR_W{1'b0}}, cmd[7:1]};
    return ext[ADDR_W-1:0];
  endfunction

  // Address counter step; natural overflow gives the modulo-2^ADDR_W wrap.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Byte counter step, holding at MAX_BYTES once the limit is reached.
  function automatic logic [4:0] cnt_sat_inc(input logic [4:0] c);
    return (c < MAX_CNT) ? (c + 5'd1) : c;
  endfunction

  // Transaction FSM with registered strobes, address and byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      mem_addr <= '0;
      dm_we    <= 1'b0;
      sr_load  <= 1'b0;
      miso_en  <= 1'b0;
      busy     <= 1'b0;
      byte_cnt <= 5'd0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      dm_we   <= 1'b0;
      sr_load <= 1'b0;

      if (state != IDLE && cs_n) begin
        // Deselect aborts whatever is in flight, including a byte boundary
        // landing in the same clk; the partial byte is simply dropped.
        state   <= IDLE;
        busy    <= 1'b0;
        miso_en <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        // Edges are counted in every active state so none is lost while the
        // single-cycle states are in progress.
        if (state != IDLE && sclk_posedge) begin
          bit_cnt <= bit_cnt + 3'd1;
        end

        case (state)
          IDLE: begin
            if (!cs_n) begin
              state    <= CMD;
              busy     <= 1'b1;
              bit_cnt  <= 3'd0;
              byte_cnt <= 5'd0;
            end
          end

          CMD: begin
            if (byte_done) begin
              state <= DECODE;
            end
          end

          DECODE: begin
            // Shift register already holds the full command byte here.
            mem_addr <= cmd_addr(sr_pdata);
            state    <= sr_pdata[0] ? RD_FETCH : WR_DATA;
          end

          WR_DATA: begin
            if (byte_done) begin
              state <= WR_COMMIT;
              dm_we <= below_max;
            end
          end

          WR_COMMIT: begin
            mem_addr <= addr_inc(mem_addr);
            byte_cnt <= cnt_sat_inc(byte_cnt);
            state    <= WR_DATA;
          end

          RD_FETCH: begin
            // Memory read data becomes valid at the end of this cycle.
            state   <= RD_LOAD;
            sr_load <= 1'b1;
          end

          RD_LOAD: begin
            state   <= RD_SHIFT;
            miso_en <= below_max;
          end

          RD_SHIFT: begin
            if (byte_done) begin
              mem_addr <= addr_inc(mem_addr);
              byte_cnt <= cnt_sat_inc(byte_cnt);
              miso_en  <= 1'b0;
              state    <= RD_FETCH;
            end
          end

          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            miso_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
